// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared widths, reset defaults and conceptual state encoding for the pattern detector
package seq_det_pkg;
    function automatic int lw(input int n);
        return $clog2(n + 1);
    endfunction
    localparam logic [15:0] PKG_PAT = 16'h0009;
    localparam int PKG_LEN = 4;
    localparam bit PKG_OVL = 1'b0;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COMPARE, ST_DETECT} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector with overlap mode,
// qualified input and a saturating match counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(PKG_PAT),
    parameter int                 DEF_LEN = PKG_LEN,
    parameter bit                 DEF_OVL = PKG_OVL,
    localparam int                LW      = lw(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_ovl,
    input  logic               x_vld,
    input  logic               x,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt
);
    logic [MAX_LEN-1:0] hist, hist_nx, pat, mask;
    logic [LW-1:0]      fill, fill_nx, len;
    logic               ovl, acc, hit;

    assign acc     = x_vld & ~cfg_we;
    assign hist_nx = acc ? {hist[MAX_LEN-2:0], x} : hist;
    assign fill_nx = (acc && fill != LW'(MAX_LEN)) ? fill + 1'b1 : fill;
    // only the low len bits of history take part in the compare
    assign mask    = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(len));
    assign hit     = acc && len != '0 && fill_nx >= len && ((hist_nx ^ pat) & mask) == '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= DEF_PAT;
            len  <= LW'(DEF_LEN);
            ovl  <= DEF_OVL;
            y    <= 1'b0;
        end else if (cfg_we) begin
            pat  <= cfg_pat;
            len  <= cfg_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
            ovl  <= cfg_ovl;
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else begin
            hist <= hist_nx;
            fill <= (hit && !ovl) ? '0 : fill_nx;
            y    <= hit;
        end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_we),
        .inc (hit),
        .q   (match_cnt)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed checks of the detector against a queue-based model
module tb_seq_detector_param;
    logic       clk = 0, rst = 1, cfg_we = 0, cfg_ovl = 0, x_vld = 0, x = 0;
    logic [7:0] cfg_pat = 0;
    logic [3:0] cfg_len = 0;
    logic       y, y_s;
    logic [7:0] match_cnt;
    logic [1:0] cnt_s;
    int         n_vec = 0, n_err = 0;

    logic [7:0] m_pat;
    int         m_len, avail, e_cnt, e_cnt_s;
    bit         m_ovl, e_y;
    bit         hist_q[$];

    wire [11:0] obs = {y, match_cnt, y_s, cnt_s};

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .x_vld(x_vld), .x(x), .y(y), .match_cnt(match_cnt)
    );
    seq_detector_param #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .x_vld(x_vld), .x(x), .y(y_s), .match_cnt(cnt_s)
    );

    function automatic void model_reset();
        m_pat = 8'h09; m_len = 4; m_ovl = 0;
        hist_q.delete(); avail = 0; e_y = 0; e_cnt = 0; e_cnt_s = 0;
    endfunction

    // accepted bits kept as a plain list; a match is the last len bits read back against the pattern
    function automatic void model_edge();
        bit ok;
        if (cfg_we) begin
            m_pat = cfg_pat; m_len = cfg_len > 8 ? 8 : int'(cfg_len); m_ovl = cfg_ovl;
            hist_q.delete(); avail = 0; e_y = 0; e_cnt = 0; e_cnt_s = 0;
        end else if (x_vld) begin
            hist_q.push_back(x);
            avail++;
            ok = m_len != 0 && avail >= m_len;
            for (int i = 0; i < m_len && ok; i++)
                if (hist_q[hist_q.size() - m_len + i] != m_pat[m_len-1-i]) ok = 0;
            e_y = ok;
            if (ok) begin
                e_cnt   = e_cnt < 255 ? e_cnt + 1 : 255;
                e_cnt_s = e_cnt_s < 3 ? e_cnt_s + 1 : 3;
                if (!m_ovl) avail = 0;
            end
        end else e_y = 0;
    endfunction

    function automatic logic [11:0] exp_vec();
        return {e_y, 8'(e_cnt), e_y, 2'(e_cnt_s)};
    endfunction

    task automatic drive(input bit we, input logic [7:0] p, input logic [3:0] l, input bit o,
                         input bit v, input bit b);
        cfg_we = we; cfg_pat = p; cfg_len = l; cfg_ovl = o; x_vld = v; x = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic feed(input bit b);
        drive(0, 0, 0, 0, 1, b);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
        drive(1, p, l, o, 0, 0);
    endtask

    bit stream[19] = '{0,1,0,0,1,0,1,1,0,0,1,0,0,1,0,1,0,0,1};

    task automatic test_reset();
        #2 rst = 0;
        #1;
        n_vec++;
        if (obs !== 12'h000) begin n_err++; $display("FAIL reset: got %h want 000", obs); end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        drive(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (obs !== 12'h000) begin n_err++; $display("FAIL reset_idle: got %h want 000", obs); end
    endtask

    task automatic test_stream(input bit ovl, input int want_cnt);
        int pulses = 0;
        if (ovl) cfg(8'h09, 4, 1);
        for (int i = 0; i < 19; i++) begin
            feed(stream[i]);
            pulses += int'(y);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL stream ovl=%0d bit %0d: got %h want %h", ovl, i, obs, exp_vec());
            end
            n_vec++;
            if (y !== (i == 4 || i == 10 || i == 18 || (ovl && i == 13))) begin
                n_err++; $display("FAIL pulse_pos ovl=%0d bit %0d: got %b", ovl, i, y);
            end
        end
        n_vec++;
        if (match_cnt !== 8'(want_cnt) || pulses != want_cnt) begin
            n_err++; $display("FAIL stream_cnt ovl=%0d: got %0d/%0d want %0d", ovl, match_cnt, pulses, want_cnt);
        end
    endtask

    task automatic test_gapped();
        bit vb[4] = '{1,0,0,1};
        int pulses = 0;
        cfg(8'h09, 4, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, !i[0], i[0] ? 1'($urandom) : vb[i/2]);
            pulses += int'(y);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL gapped cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (i == 6) begin
                n_vec++;
                if (y !== 1'b1) begin n_err++; $display("FAIL gapped_last: got %b want 1", y); end
            end
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL gapped_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_cfg_edges();
        bit b;
        int pulses = 0;
        cfg(8'($urandom), 0, 1'($urandom));
        for (int i = 0; i < 40; i++) begin
            feed(1'($urandom));
            pulses += int'(y);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL len0 cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL len0_pulses: got %0d want 0", pulses); end
        cfg(8'hA5, 15, 0);
        for (int i = 7; i >= 0; i--) begin
            b = (i == 0 || i == 2 || i == 5 || i == 7);
            feed(b);
            n_vec++;
            if (obs !== exp_vec() || y !== (i == 0)) begin
                n_err++; $display("FAIL clamp bit %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        cfg(8'h09, 4, 0);
        feed(1); feed(0); feed(0); feed(1);
        drive(1, 8'h09, 4, 0, 1, 1);
        n_vec++;
        if (match_cnt !== 8'd0 || y !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL cfg_vld: got %h want cnt 0 y 0", obs);
        end
        feed(0); feed(0); feed(1);
        n_vec++;
        if (y !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL dropped_bit: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_rst_mid();
        cfg(8'h09, 4, 0);
        feed(1); feed(0); feed(0); feed(1);
        n_vec++;
        if (y !== 1'b1 || match_cnt !== 8'd1) begin
            n_err++; $display("FAIL pre_rst: got y %b cnt %0d want 1/1", y, match_cnt);
        end
        feed(1); feed(0); feed(0);
        #2 rst = 0;
        #1;
        n_vec++;
        if (obs !== 12'h000) begin n_err++; $display("FAIL async_rst: got %h want 000", obs); end
        model_reset();
        @(posedge clk);
        #1 rst = 1;
        feed(1);
        n_vec++;
        if (y !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL prefix_lost: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, runs = 0;
        cfg(8'h03, 2, 1);
        for (int i = 0; i < 6; i++) begin
            feed(1);
            pulses += int'(y_s);
            runs += int'(i >= 2 && y && y_s);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL b2b cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (pulses != 5 || runs != 4 || cnt_s !== 2'd3 || match_cnt !== 8'd5) begin
            n_err++; $display("FAIL saturate: got pulses %0d cnt_s %0d cnt %0d want 5/3/5", pulses, cnt_s, match_cnt);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            cfg(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 99) < 2)
                    drive(1, 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
                else
                    drive(0, 8'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom));
                n_vec++;
                if (obs !== exp_vec()) begin
                    n_err++; $display("FAIL random r%0d c%0d: got %h want %h", r, i, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream(0, 3);
        test_stream(1, 4);
        test_gapped();
        test_cfg_edges();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
